hsv_div_arbiter: RTL and testbench
==================================

Name: hsv_div_arbiter

Overview:
- Shares one pipelined fixed-latency divider instance (div_gen_0 configuration: 10-bit dividend, 4-bit divisor, 10-bit quotient, no backpressure) between NUM_REQ requesters.
- Typical requesters: the saturation and hue paths of the HSV converter, plus later colour-stat blocks.
- Arbitrates round-robin, issues at most one division per cycle, and tracks in-flight operations with a tag pipeline. Each quotient is routed back to its requester.
- Handles divide-by-zero locally and flags any divider output it cannot match to a tag.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- LATENCY, 12, divider cycles from an accepted input to a valid output (fixed).
- DIVIDEND_W, 10, dividend width.
- DIVISOR_W, 4, divisor width.
- QUOT_W, 10, quotient width.

Ports:
- clk_in  input  1  system clock.
- rstn_in  input  1  asynchronous active-low reset.
- req_valid_in  input  NUM_REQ  per-requester request valid.
- req_dividend_in  input  NUM_REQ*DIVIDEND_W  packed dividends; requester i is at slice i.
- req_divisor_in  input  NUM_REQ*DIVISOR_W  packed divisors.
- req_ready_out  output  NUM_REQ  one-hot grant; a transfer happens when valid and ready are both high.
- div_dividend_out  output  DIVIDEND_W  to divider s_axis_dividend_tdata.
- div_divisor_out  output  DIVISOR_W  to divider s_axis_divisor_tdata.
- div_valid_out  output  1  drives both divider tvalid inputs.
- div_quot_in  input  QUOT_W  from divider m_axis_dout_tdata.
- div_valid_in  input  1  from divider m_axis_dout_tvalid.
- rsp_valid_out  output  NUM_REQ  one-hot; pulses for 1 cycle when a result is delivered.
- rsp_quot_out  output  QUOT_W  shared result bus, qualified by rsp_valid_out.
- rsp_dz_out  output  1  result came from a divide-by-zero.
- err_out  output  1  sticky: orphan or missing divider result.

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - Outputs: req_ready_out=0, div_valid_out=0, rsp_valid_out=0, rsp_quot_out=0, rsp_dz_out=0, err_out=0.
  - Internal state: RR pointer=0, tag pipe all invalid, blank counter=LATENCY.
- Blanking:
  - While the blank counter is nonzero, no grants are issued and div_valid_in is ignored, with no error.
  - The counter decrements once per cycle.
  - Purpose: drain results from the divider, which has no reset, that were in flight before reset.
  - Reset asserted mid-operation drops all in-flight results silently.
- Arbitration:
  - Combinational from req_valid_in and the RR pointer. The grant goes to the first valid requester at or after the pointer, wrapping.
  - req_ready_out may depend on req_valid_in.
  - On a grant to requester i, the pointer becomes (i+1) mod NUM_REQ. With no valid requester, the pointer holds.
- Issue, same cycle as the grant (0-cycle issue):
  - Divisor != 0: div_valid_out=1, with the granted requester's dividend and divisor muxed onto the divider inputs.
  - Divisor == 0: div_valid_out=0, and the op is still pushed into the tag pipe with dz=1.
  - No grant: div_valid_out=0, data outputs are don't-care (drive 0).
- Tag pipeline:
  - LATENCY-deep shift register of {valid, dz, id[$clog2(NUM_REQ)-1:0]}, shifted every cycle.
  - Stage 0 is loaded with the grant (valid=0 if no grant).
  - The head is the tag issued LATENCY cycles earlier.
- Response, registered, one cycle after the head is evaluated. Total latency from grant to rsp_valid_out is LATENCY+1 cycles.
  - Head valid, dz=0, div_valid_in=1: rsp_valid_out[id]=1, rsp_quot_out=div_quot_in, rsp_dz_out=0.
  - Head valid, dz=1: rsp_valid_out[id]=1, rsp_quot_out=all ones, rsp_dz_out=1. A simultaneous div_valid_in=1 is an orphan error.
  - Head valid, dz=0, div_valid_in=0: missing-result error; no rsp pulse.
  - Head invalid, div_valid_in=1 (outside blanking): orphan error; the quotient is dropped.
  - When no response is delivered, rsp_quot_out and rsp_dz_out hold their previous values.
- err_out sets on any error above and clears only on reset.
- Throughput: 1 op/cycle sustained; a single requester holding valid continuously is granted every cycle.
- Width rules: inputs are passed through unmodified; no truncation inside the block.

Decomposition:
- Package hsv_div_pkg holds:
  - typedef div_tag_t {logic valid; logic dz; logic [ID_W-1:0] id;}
  - localparam DIV_LATENCY=12
  - DIV dividend, divisor and quotient widths
  - function rr_pick(req, ptr) returning the one-hot grant.
- One natural sub-module: div_tag_pipe, the parameterised LATENCY-deep tag shift register exposing its head.
- The arbiter FSM, blank counter and response logic stay in hsv_div_arbiter.

Test Plan:
- Reset release, divider model emitting stray div_valid_in on cycles 3 and 9 after release -> no grants, err_out stays 0; req_ready_out first rises on cycle 12 after release.
- Req 0 alone, dividend 510, divisor 15, held one cycle after blanking -> div_valid_out=1 in the grant cycle; rsp_valid_out=01 and rsp_quot_out=34 exactly 13 cycles later.
- Both requesters valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; responses return in the same order with matching quotients; no stall cycles.
- Req 1, divisor 0, dividend 300 -> div_valid_out stays 0; 13 cycles later rsp_valid_out=10, rsp_quot_out=1023, rsp_dz_out=1.
- Divider model drops one result (suppresses div_valid_in) -> err_out=1 at the next edge and stays 1; the other in-flight results are still delivered.
- rstn_in pulsed low with 5 ops in flight -> all outputs 0 immediately; the 5 late divider results arrive during blanking and are ignored; err_out=0.

Source files
------------

// File: rtl/hsv_div_pkg.sv
// Shared types, widths and the round-robin pick helper for the divider arbiter.
package hsv_div_pkg;

  localparam int unsigned DIV_LATENCY    = 12;
  localparam int unsigned DIV_DIVIDEND_W = 10;
  localparam int unsigned DIV_DIVISOR_W  = 4;
  localparam int unsigned DIV_QUOT_W     = 10;
  localparam int unsigned MAX_REQ        = 8;
  localparam int unsigned ID_W           = $clog2(MAX_REQ);

  typedef struct packed {
    logic            valid;
    logic            dz;
    logic [ID_W-1:0] id;
  } div_tag_t;

  typedef enum logic {
    ST_BLANK,
    ST_RUN
  } arb_state_e;

  // One-hot grant to the first valid requester at or after ptr, wrapping at n.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [ID_W-1:0]    ptr,
                                                 input int unsigned        n);
    logic [MAX_REQ-1:0] gnt;
    int unsigned        idx;
    gnt = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        idx = (32'(ptr) + k) % n;
        if (gnt == '0 && req[idx[ID_W-1:0]]) gnt[idx[ID_W-1:0]] = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/div_tag_pipe.sv
// LATENCY-deep tag shift register; head_o is the tag loaded LATENCY cycles ago.
module div_tag_pipe
  import hsv_div_pkg::*;
#(
  parameter int unsigned LATENCY = DIV_LATENCY
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  div_tag_t tag_i,
  output div_tag_t head_o
);

  div_tag_t pipe_q [LATENCY];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_i;
      for (int unsigned i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign head_o = pipe_q[LATENCY-1];

endmodule

// File: rtl/hsv_div_arbiter.sv
// Round-robin sharing of one fixed-latency divider between NUM_REQ requesters,
// with local divide-by-zero handling and tag-tracked result routing.
module hsv_div_arbiter
  import hsv_div_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned LATENCY    = DIV_LATENCY,
  parameter int unsigned DIVIDEND_W = DIV_DIVIDEND_W,
  parameter int unsigned DIVISOR_W  = DIV_DIVISOR_W,
  parameter int unsigned QUOT_W     = DIV_QUOT_W
) (
  input  logic                          clk_in,
  input  logic                          rstn_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  input  logic [NUM_REQ*DIVIDEND_W-1:0] req_dividend_in,
  input  logic [NUM_REQ*DIVISOR_W-1:0]  req_divisor_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  output logic [DIVIDEND_W-1:0]         div_dividend_out,
  output logic [DIVISOR_W-1:0]          div_divisor_out,
  output logic                          div_valid_out,
  input  logic [QUOT_W-1:0]             div_quot_in,
  input  logic                          div_valid_in,
  output logic [NUM_REQ-1:0]            rsp_valid_out,
  output logic [QUOT_W-1:0]             rsp_quot_out,
  output logic                          rsp_dz_out,
  output logic                          err_out
);

  localparam int unsigned BLANK_W = $clog2(LATENCY + 1);

  arb_state_e          state_q, state_d;
  logic [BLANK_W-1:0]  blank_q, blank_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [QUOT_W-1:0]   rsp_quot_q, rsp_quot_d;
  logic                rsp_dz_q, rsp_dz_d;
  logic                err_q, err_d;

  logic [MAX_REQ-1:0]    grant_full;
  logic [ID_W-1:0]       gidx;
  logic [DIVIDEND_W-1:0] sel_dividend;
  logic [DIVISOR_W-1:0]  sel_divisor;
  logic                  any_grant;
  logic                  dz_sel;
  div_tag_t              tag_in;
  div_tag_t              head;

  always_comb begin
    grant_full   = '0;
    gidx         = '0;
    sel_dividend = '0;
    sel_divisor  = '0;
    if (state_q == ST_RUN) grant_full = rr_pick(MAX_REQ'(req_valid_in), ptr_q, NUM_REQ);
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_full[i[ID_W-1:0]]) begin
        gidx         = i[ID_W-1:0];
        sel_dividend = req_dividend_in[i*DIVIDEND_W +: DIVIDEND_W];
        sel_divisor  = req_divisor_in[i*DIVISOR_W +: DIVISOR_W];
      end
    end
  end

  assign any_grant = |grant_full;
  assign dz_sel    = (sel_divisor == '0);

  // Zero-divisor ops never reach the divider but still occupy a tag slot so
  // their response comes back in order with the real quotients.
  assign tag_in = '{valid: any_grant, dz: any_grant & dz_sel, id: gidx};

  assign req_ready_out    = grant_full[NUM_REQ-1:0];
  assign div_valid_out    = any_grant & ~dz_sel;
  assign div_dividend_out = sel_dividend;
  assign div_divisor_out  = sel_divisor;

  div_tag_pipe #(
    .LATENCY(LATENCY)
  ) u_tag_pipe (
    .clk_i (clk_in),
    .rst_ni(rstn_in),
    .tag_i (tag_in),
    .head_o(head)
  );

  always_comb begin
    state_d = state_q;
    blank_d = blank_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_BLANK: begin
        blank_d = blank_q - 1'b1;
        if (blank_q == BLANK_W'(1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (any_grant) ptr_d = (32'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
      end
      default: state_d = ST_BLANK;
    endcase
  end

  always_comb begin
    rsp_valid_d = '0;
    rsp_quot_d  = rsp_quot_q;
    rsp_dz_d    = rsp_dz_q;
    err_d       = err_q;
    if (state_q == ST_RUN) begin
      if (head.valid) begin
        if (head.dz || div_valid_in) begin
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (head.id == i[ID_W-1:0]) rsp_valid_d[i] = 1'b1;
          end
        end
        if (head.dz) begin
          rsp_quot_d = '1;
          rsp_dz_d   = 1'b1;
          if (div_valid_in) err_d = 1'b1;
        end else if (div_valid_in) begin
          rsp_quot_d = div_quot_in;
          rsp_dz_d   = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end else if (div_valid_in) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state_q     <= ST_BLANK;
      blank_q     <= BLANK_W'(LATENCY);
      ptr_q       <= '0;
      rsp_valid_q <= '0;
      rsp_quot_q  <= '0;
      rsp_dz_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      blank_q     <= blank_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_quot_q  <= rsp_quot_d;
      rsp_dz_q    <= rsp_dz_d;
      err_q       <= err_d;
    end
  end

  assign rsp_valid_out = rsp_valid_q;
  assign rsp_quot_out  = rsp_quot_q;
  assign rsp_dz_out    = rsp_dz_q;
  assign err_out       = err_q;

endmodule

// File: tb/tb_hsv_div_arbiter.sv
// Directed bench for hsv_div_arbiter with a behavioural 12-cycle divider and an in-order scoreboard.
module tb_hsv_div_arbiter;

  localparam int LAT = 12;

  logic        clk_in = 1'b0;
  logic        rstn_in;
  logic [1:0]  req_valid_in;
  logic [19:0] req_dividend_in;
  logic [7:0]  req_divisor_in;
  logic [1:0]  req_ready_out;
  logic [9:0]  div_dividend_out;
  logic [3:0]  div_divisor_out;
  logic        div_valid_out;
  logic [9:0]  div_quot_in;
  logic        div_valid_in;
  logic [1:0]  rsp_valid_out;
  logic [9:0]  rsp_quot_out;
  logic        rsp_dz_out;
  logic        err_out;

  logic        stray;
  logic        drop_issue;
  logic        dm_v [LAT];
  logic [9:0]  dm_q [LAT];

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [1:0] oh;
    logic [9:0] q;
    logic       dz;
    int         at;
  } exp_t;
  exp_t exp_q[$];

  hsv_div_arbiter #(
    .NUM_REQ(2),
    .LATENCY(LAT)
  ) dut (
    .clk_in          (clk_in),
    .rstn_in         (rstn_in),
    .req_valid_in    (req_valid_in),
    .req_dividend_in (req_dividend_in),
    .req_divisor_in  (req_divisor_in),
    .req_ready_out   (req_ready_out),
    .div_dividend_out(div_dividend_out),
    .div_divisor_out (div_divisor_out),
    .div_valid_out   (div_valid_out),
    .div_quot_in     (div_quot_in),
    .div_valid_in    (div_valid_in),
    .rsp_valid_out   (rsp_valid_out),
    .rsp_quot_out    (rsp_quot_out),
    .rsp_dz_out      (rsp_dz_out),
    .err_out         (err_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Divider stand-in: no reset, fixed latency, optional result suppression.
  always @(posedge clk_in) begin
    dm_v[0] <= div_valid_out & ~drop_issue;
    dm_q[0] <= (div_divisor_out != 4'd0) ? div_dividend_out / div_divisor_out : 10'h3FF;
    for (int i = 1; i < LAT; i++) begin
      dm_v[i] <= dm_v[i-1];
      dm_q[i] <= dm_q[i-1];
    end
  end

  assign div_valid_in = dm_v[LAT-1] | stray;
  assign div_quot_in  = dm_q[LAT-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk_in) begin
    if (rstn_in === 1'b1 && rsp_valid_out !== 2'b00) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid_out), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_valid", 32'(rsp_valid_out), 32'(e.oh));
        check("rsp_quot", 32'(rsp_quot_out), 32'(e.q));
        check("rsp_dz", 32'(rsp_dz_out), 32'(e.dz));
        check("rsp_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  // One clock cycle: drive, check the combinational grant/issue at the negedge,
  // log the expected response, then move to just after the next posedge.
  task automatic step(input logic [1:0] v, input logic [9:0] d0, input logic [3:0] s0,
                      input logic [9:0] d1, input logic [3:0] s1, input logic [1:0] exp_g,
                      input logic stray_i, input logic drop_i);
    logic [9:0] d;
    logic [3:0] s;
    exp_t       e;
    req_valid_in    = v;
    req_dividend_in = {d1, d0};
    req_divisor_in  = {s1, s0};
    stray           = stray_i;
    drop_issue      = drop_i;
    @(negedge clk_in);
    check("grant", 32'(req_ready_out), 32'(exp_g));
    if (exp_g != 2'b00) begin
      d = exp_g[0] ? d0 : d1;
      s = exp_g[0] ? s0 : s1;
      check("div_valid", 32'(div_valid_out), 32'(s != 4'd0));
      if (s != 4'd0) begin
        check("div_dividend", 32'(div_dividend_out), 32'(d));
        check("div_divisor", 32'(div_divisor_out), 32'(s));
      end
      if (!drop_i) begin
        e.oh = exp_g;
        e.q  = (s == 4'd0) ? 10'd1023 : d / s;
        e.dz = (s == 4'd0);
        e.at = cyc + LAT + 1;
        exp_q.push_back(e);
      end
    end else begin
      check("div_valid_idle", 32'(div_valid_out), 32'd0);
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 10'd0, 4'd0, 10'd0, 4'd0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(req_ready_out), 32'd0);
    check({tag, "_div_valid"}, 32'(div_valid_out), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid_out), 32'd0);
    check({tag, "_rsp_quot"}, 32'(rsp_quot_out), 32'd0);
    check({tag, "_rsp_dz"}, 32'(rsp_dz_out), 32'd0);
    check({tag, "_err"}, 32'(err_out), 32'd0);
  endtask

  initial begin
    int c_d;
    for (int i = 0; i < LAT; i++) begin
      dm_v[i] = 1'b0;
      dm_q[i] = 10'd0;
    end
    rstn_in         = 1'b0;
    req_valid_in    = 2'b00;
    req_dividend_in = '0;
    req_divisor_in  = '0;
    stray           = 1'b0;
    drop_issue      = 1'b0;

    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_all_zero("reset");
    @(posedge clk_in);
    #1;
    rstn_in = 1'b1;

    // Blanking: req 0 waits, strays on cycles 3 and 9 are ignored.
    for (int k = 0; k < LAT; k++)
      step(2'b01, 10'd510, 4'd15, 10'd0, 4'd0, 2'b00, (k == 3 || k == 9), 1'b0);
    check("blank_err", 32'(err_out), 32'd0);
    step(2'b01, 10'd510, 4'd15, 10'd0, 4'd0, 2'b01, 1'b0, 1'b0);

    // Req 1 divide-by-zero.
    step(2'b10, 10'd0, 4'd0, 10'd300, 4'd0, 2'b10, 1'b0, 1'b0);

    // Both requesters continuously: grants alternate with no stall.
    for (int k = 0; k < 6; k++)
      step(2'b11, 10'(100 + 50 * k), 4'(k + 3), 10'(999 - 77 * k), 4'(k + 1),
           (k % 2 == 0) ? 2'b01 : 2'b10, 1'b0, 1'b0);
    idle(LAT + 3);
    check("sb_empty_1", 32'(exp_q.size()), 32'd0);
    check("err_clean", 32'(err_out), 32'd0);

    // Missing divider result.
    c_d = cyc;
    step(2'b01, 10'd200, 4'd9, 10'd0, 4'd0, 2'b01, 1'b0, 1'b1);
    step(2'b10, 10'd0, 4'd0, 10'd777, 4'd5, 2'b10, 1'b0, 1'b0);
    step(2'b01, 10'd63, 4'd2, 10'd0, 4'd0, 2'b01, 1'b0, 1'b0);
    while (cyc < c_d + LAT) idle(1);
    @(negedge clk_in);
    check("err_before_miss", 32'(err_out), 32'd0);
    @(posedge clk_in);
    #1;
    @(negedge clk_in);
    check("err_after_miss", 32'(err_out), 32'd1);
    @(posedge clk_in);
    #1;
    idle(LAT);
    check("err_sticky", 32'(err_out), 32'd1);
    check("sb_empty_2", 32'(exp_q.size()), 32'd0);

    // Five ops in flight from one requester, then an async reset pulse.
    for (int k = 0; k < 5; k++)
      step(2'b01, 10'(40 + 11 * k), 4'(k + 2), 10'd0, 4'd0, 2'b01, 1'b0, 1'b0);
    req_valid_in = 2'b00;
    rstn_in      = 1'b0;
    #1;
    check_all_zero("async_rst");
    exp_q.delete();
    @(posedge clk_in);
    #1;
    rstn_in = 1'b1;
    for (int k = 0; k < LAT; k++)
      step(2'b10, 10'd0, 4'd0, 10'd1023, 4'd7, 2'b00, 1'b0, 1'b0);
    check("post_rst_err", 32'(err_out), 32'd0);
    step(2'b10, 10'd0, 4'd0, 10'd1023, 4'd7, 2'b10, 1'b0, 1'b0);
    idle(LAT + 3);
    check("final_err", 32'(err_out), 32'd0);
    check("sb_empty_3", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
